// File: rtl/cmem_responder.sv
// Scratchpad memory responder for the cmem read/write/resp handshake.
// Optional open-row fast path enabled by defining CMEM_RESP_ROWBUF_EN.
module cmem_responder #(
   parameter int ADDR_WIDTH = 12,
   parameter int LATENCY    = 2,
   parameter int ROW_BITS   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [3:0]  mem_byte_enable,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_wdata,
   output logic        mem_resp,
   output logic [31:0] mem_rdata,
   output logic        mem_hit
);
   localparam int IDX_W = ADDR_WIDTH - 2;
   localparam int DEPTH = 2 ** IDX_W;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              hit_q, hit_d;
   logic [31:0]       rdata_q;
   logic              row_hit;
   logic [31:0]       ram [DEPTH];

   logic unused_addr_bits;
   assign unused_addr_bits = ^{mem_address[31:ADDR_WIDTH], mem_address[1:0]};

`ifdef CMEM_RESP_ROWBUF_EN
   localparam int ROW_W = IDX_W - ROW_BITS;
   logic [ROW_W-1:0] row_q;
   logic             row_vld_q;

   assign row_hit = row_vld_q && (mem_address[ADDR_WIDTH-1:2+ROW_BITS] == row_q);

   // The open row follows every completed access, hit or miss.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q     <= '0;
         row_vld_q <= 1'b0;
      end else if (state_q == RESP) begin
         row_q     <= idx_q[IDX_W-1:ROW_BITS];
         row_vld_q <= 1'b1;
      end
   end
`else
   localparam int unused_row_bits = ROW_BITS;
   assign row_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      idx_d   = idx_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      hit_d   = hit_q;
      case (state_q)
         IDLE: begin
            if (mem_read || mem_write) begin
               rd_d    = mem_read;
               wr_d    = mem_write;
               idx_d   = mem_address[ADDR_WIDTH-1:2];
               be_d    = mem_byte_enable;
               wdata_d = mem_wdata;
               hit_d   = row_hit;
               cnt_d   = row_hit ? 4'd0 : 4'(LATENCY - 1);
               state_d = (cnt_d == 4'd0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         idx_q   <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         hit_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         idx_q   <= idx_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         hit_q   <= hit_d;
         // Read data is captured on entry to RESP, before any write in RESP commits.
         if (state_d == RESP && state_q != RESP && rd_d) rdata_q <= ram[idx_d];
      end
   end

   // NOTE: the RAM array has no reset; only control state is cleared by rst_n.
   always_ff @(posedge clk) begin
      if (state_q == RESP && wr_q) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) ram[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   assign mem_resp  = (state_q == RESP);
   assign mem_rdata = rdata_q;
   assign mem_hit   = (state_q == RESP) && hit_q;
endmodule
